// File: rtl/imem_loader_pkg.sv
// +----------------------------------------------------------------------+
// | imem_loader_pkg : shared state encoding and byte-order constants     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam bit MSB_FIRST      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
// +----------------------------------------------------------------------+
// | word_packer : shifts stream bytes into a 32-bit instruction word     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_en) begin
         if (MSB_FIRST) word_d = {word_q[23:0], byte_in};
         else           word_d = {byte_in, word_q[31:8]};
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   // High on the shift that completes the current word.
   assign word_full = shift_en && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word      = word_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------+
// | imem_loader : byte-stream program loader for the instruction memory  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam int LEN_W = ADDR_WIDTH + 1;
   localparam int unsigned MEM_WORDS = 2 ** ADDR_WIDTH;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] wcnt_q, wcnt_d;
   logic [7:0]       csum_q, csum_d;
   logic             in_ready_q, in_ready_d;
   logic             imem_we_q, imem_we_d;
   logic             cpu_hold_q, cpu_hold_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             xfer;
   logic             len_bad;
   logic             pk_clear, pk_shift, pk_full;
   logic [31:0]      pk_word;

   word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (pk_clear),
      .shift_en  (pk_shift),
      .byte_in   (in_data),
      .word      (pk_word),
      .word_full (pk_full)
   );

   assign xfer    = in_valid && in_ready_q;
   assign len_bad = (in_data == 8'd0) || (32'(in_data) > MEM_WORDS);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wcnt_d     = wcnt_q;
      csum_d     = csum_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      error_d    = error_q;
      pk_clear   = 1'b0;
      pk_shift   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LEN;
               error_d    = 1'b0;
               done_d     = 1'b0;
               cpu_hold_d = 1'b1;
            end
         end
         ST_LEN: begin
            if (xfer) begin
               if (len_bad) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  len_d    = LEN_W'(in_data);
                  wcnt_d   = '0;
                  csum_d   = '0;
                  pk_clear = 1'b1;
                  state_d  = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               pk_shift = 1'b1;
               csum_d   = csum_q ^ in_data;
               if (pk_full) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = (wcnt_d == len_q) ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: begin
            if (xfer) begin
               if (in_data == csum_q) begin
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
                  state_d    = ST_DONE;
               end else begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d    = ST_LEN;
               done_d     = 1'b0;
               error_d    = 1'b0;
               cpu_hold_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
      imem_we_d  = (state_d == ST_WRITE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         wcnt_q     <= '0;
         csum_q     <= '0;
         in_ready_q <= 1'b0;
         imem_we_q  <= 1'b0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wcnt_q     <= wcnt_d;
         csum_q     <= csum_d;
         in_ready_q <= in_ready_d;
         imem_we_q  <= imem_we_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = wcnt_q[ADDR_WIDTH-1:0];
   assign imem_wdata = pk_word;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +----------------------------------------------------------------------+
// | tb_imem_loader : scoreboard-driven directed bench for imem_loader    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        imem_we;
   logic [3:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [35:0] sb[$];
   logic [31:0] img[0:15];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: pops the scoreboard on every write strobe.
   always @(posedge clk) begin
      logic [35:0] e;
      #2;
      if (imem_we === 1'b1) begin
         wr_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL spurious_we observed=addr %h data %h expected=no write", imem_addr, imem_wdata);
         end else begin
            e = sb.pop_front();
            chk("we_addr", 32'(imem_addr), 32'(e[35:32]));
            chk("we_data", imem_wdata, e[31:0]);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = b;
         got = in_ready;
         @(posedge clk);
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=no transfer expected=transfer of %h", b);
      end
   endtask

   task automatic drop();
      @(negedge clk); in_valid = 1'b0;
   endtask

   task automatic gap(input bit throttle);
      if (throttle && $urandom_range(0, 1) == 1) begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk); in_valid = 1'b0;
         end
      end
   endtask

   // Sends words img[0..nw-1] after length byte n; checksum optionally corrupted.
   task automatic send_image(input int n, input int nw, input bit good, input bit throttle, input bit send_csum);
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      logic [31:0] w;
      send_byte(8'(n));
      for (int i = 0; i < nw; i++) begin
         w = img[i];
         sb.push_back({4'(i), w});
         for (int j = 0; j < 4; j++) begin
            b = w[31 - 8*j -: 8];
            gap(throttle);
            send_byte(b);
            x = x ^ b;
         end
      end
      if (send_csum) begin
         gap(throttle);
         send_byte(good ? x : (x ^ 8'h01));
      end
      drop();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(error), 32'd0);
      chk({tag, "_we"}, 32'(imem_we), 32'd0);
   endtask

   initial begin
      int w0;
      // Reset asserted mid-cycle, released on a falling edge.
      #3 reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_idle_outputs("rst");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_we", 32'(imem_we), 32'd0);
      end
      chk("idle_ready", 32'(in_ready), 32'd0);

      // Single-word load.
      img[0] = 32'h20080005;
      w0 = wr_count;
      pulse_start();
      chk("len_ready", 32'(in_ready), 32'd1);
      send_image(1, 1, 1'b1, 1'b0, 1'b1);
      chk("sw_done", 32'(done), 32'd1);
      chk("sw_hold", 32'(cpu_hold), 32'd0);
      chk("sw_err", 32'(error), 32'd0);
      chk("sw_ready", 32'(in_ready), 32'd0);
      chk("sw_writes", 32'(wr_count - w0), 32'd1);

      // Re-load from DONE: flags flip on the start edge.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("reload_done", 32'(done), 32'd0);
      chk("reload_hold", 32'(cpu_hold), 32'd1);
      img[0] = 32'hDEADBEEF;
      img[1] = 32'h8C010004;
      w0 = wr_count;
      send_image(2, 2, 1'b1, 1'b0, 1'b1);
      chk("reload_ok", 32'(done), 32'd1);
      chk("reload_writes", 32'(wr_count - w0), 32'd2);

      // Checksum mismatch (20 08 00 05 with checksum 2C).
      img[0] = 32'h20080005;
      w0 = wr_count;
      pulse_start();
      send_image(1, 1, 1'b0, 1'b0, 1'b1);
      chk("cs_err", 32'(error), 32'd1);
      chk("cs_done", 32'(done), 32'd0);
      chk("cs_hold", 32'(cpu_hold), 32'd1);
      chk("cs_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("cs_writes", 32'(wr_count - w0), 32'd1);

      // Bad lengths 0x00 and 0x11, new start clears error.
      w0 = wr_count;
      pulse_start();
      chk("bl_clear", 32'(error), 32'd0);
      send_byte(8'h00);
      drop();
      chk("bl0_err", 32'(error), 32'd1);
      chk("bl0_ready", 32'(in_ready), 32'd0);
      pulse_start();
      chk("bl_clear2", 32'(error), 32'd0);
      send_byte(8'h11);
      drop();
      chk("bl11_err", 32'(error), 32'd1);
      chk("bl11_hold", 32'(cpu_hold), 32'd1);
      repeat (3) @(negedge clk);
      chk("bl_writes", 32'(wr_count - w0), 32'd0);

      // Full memory, throttled.
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      w0 = wr_count;
      pulse_start();
      send_image(16, 16, 1'b1, 1'b1, 1'b1);
      chk("full_done", 32'(done), 32'd1);
      chk("full_hold", 32'(cpu_hold), 32'd0);
      chk("full_err", 32'(error), 32'd0);
      chk("full_writes", 32'(wr_count - w0), 32'd16);

      // Reset after 2 of 4 words.
      for (int i = 0; i < 4; i++) img[i] = 32'h01000000 * (i + 1) + 32'h00ABCD00;
      w0 = wr_count;
      pulse_start();
      send_image(4, 2, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_idle_outputs("mid");
      @(negedge clk); reset = 1'b0;
      chk("mid_writes", 32'(wr_count - w0), 32'd2);
      check_idle_outputs("mid_rel");
      w0 = wr_count;
      pulse_start();
      send_image(4, 4, 1'b1, 1'b0, 1'b1);
      chk("after_done", 32'(done), 32'd1);
      chk("after_writes", 32'(wr_count - w0), 32'd4);

      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
